uart_cmd_framer: RTL and testbench

Parametrised command/response framer between a byte-level UART core and the command processor. Assembles `CMD_BYTES` received bytes (MSB first) into one command word with an inter-byte timeout that discards partial frames. Serialises a `RESP_BYTES`-wide response back through the UART transmitter. Replaces the fixed 2-byte-command / 1-byte-response wrapper.

---
 rtl/uart_frame_pkg.sv | 7 +
 rtl/uart_resp_tx.sv | 77 +++++++
 rtl/uart_cmd_framer.sv | 116 +++++++++++
 tb/tb_uart_cmd_framer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command/response framer.
package uart_frame_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;
endpackage

// File: rtl/uart_resp_tx.sv
// Response serialiser: sends a RESP_BYTES-wide word MSB byte first through the UART transmitter.
// state   | meaning
// TX_IDLE | waiting for send_resp; tx_data held at 0
// TX_LOAD | trmt strobe for the current top byte
// TX_WAIT | byte in flight, waiting for tx_done
module uart_resp_tx
  import uart_frame_pkg::*;
#(
  parameter int RESP_BYTES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BYTE_W*RESP_BYTES-1:0] resp,
  input  logic                         send_resp,
  input  logic                         tx_done,
  output logic                         resp_busy,
  output logic                         resp_done,
  output logic                         trmt,
  output logic [BYTE_W-1:0]            tx_data
);
  localparam int RW = BYTE_W * RESP_BYTES;
  localparam int IW = $clog2(RESP_BYTES + 1);

  tx_state_t       state_q, state_d;
  logic [RW-1:0]   sh_q, sh_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (send_resp) begin
          sh_d    = resp;
          idx_d   = IW'(RESP_BYTES);
          state_d = TX_LOAD;
        end
      end
      TX_LOAD: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          sh_d  = sh_q << BYTE_W;
          idx_d = idx_q - IW'(1);
          if (idx_q == IW'(1)) begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = TX_LOAD;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign trmt      = (state_q == TX_LOAD);
  assign resp_busy = (state_q != TX_IDLE);
  assign resp_done = done_q;
  assign tx_data   = resp_busy ? sh_q[RW-1 -: BYTE_W] : '0;
endmodule

// File: rtl/uart_cmd_framer.sv
// Command/response framer: assembles CMD_BYTES UART bytes into a command word with an inter-byte timeout.
// state      | meaning
// RX_IDLE    | no partial frame held
// RX_COLLECT | partial frame held, timeout counter running
module uart_cmd_framer
  import uart_frame_pkg::*;
#(
  parameter int CMD_BYTES    = 2,
  parameter int RESP_BYTES   = 1,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_rdy,
  input  logic [BYTE_W-1:0]            rx_data,
  output logic                         clr_rx_rdy,
  output logic [BYTE_W*CMD_BYTES-1:0]  cmd,
  output logic                         cmd_rdy,
  input  logic                         clr_cmd_rdy,
  output logic                         overrun,
  output logic                         frame_err,
  input  logic [BYTE_W*RESP_BYTES-1:0] resp,
  input  logic                         send_resp,
  output logic                         resp_busy,
  output logic                         resp_done,
  output logic                         trmt,
  output logic [BYTE_W-1:0]            tx_data,
  input  logic                         tx_done
);
  localparam int CW    = BYTE_W * CMD_BYTES;
  localparam int CNT_W = $clog2(CMD_BYTES + 1);
  localparam int TO_W  = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

  rx_state_t         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     sh_q, sh_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [CW-1:0]     cmd_q;
  logic              cmd_rdy_q, overrun_q, frame_err_q;
  logic              frame_done, timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      to_q        <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      to_q        <= to_d;
      if (frame_done) cmd_q <= sh_d;
      // completion outranks the consumer's acknowledge
      if (frame_done) cmd_rdy_q <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      overrun_q   <= frame_done & cmd_rdy_q;
      frame_err_q <= timeout_hit;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    to_d        = to_q;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    if (rx_rdy) begin
      sh_d = CW'({sh_q, rx_data});
      to_d = '0;
      if (cnt_q == CNT_LAST) begin
        frame_done = 1'b1;
        cnt_d      = '0;
        rx_state_d = RX_IDLE;
      end else begin
        cnt_d      = cnt_q + CNT_W'(1);
        rx_state_d = RX_COLLECT;
      end
    end else if (TIMEOUT_CLKS != 0 && rx_state_q == RX_COLLECT) begin
      if (to_q == TO_LAST) begin
        timeout_hit = 1'b1;
        cnt_d       = '0;
        sh_d        = '0;
        to_d        = '0;
        rx_state_d  = RX_IDLE;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
  end

  assign clr_rx_rdy = rx_rdy;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

  uart_resp_tx #(.RESP_BYTES(RESP_BYTES)) u_resp_tx (
    .clk       (clk),
    .rst       (rst),
    .resp      (resp),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .resp_busy (resp_busy),
    .resp_done (resp_done),
    .trmt      (trmt),
    .tx_data   (tx_data)
  );
endmodule

// File: tb/tb_uart_cmd_framer.sv
// Scoreboard bench for uart_cmd_framer: byte-queue frame model on RX, byte-list model on TX.
module tb_uart_cmd_framer;
  localparam int CB = 3;
  localparam int RB = 2;
  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        overrun, frame_err;
  logic [15:0] resp = '0;
  logic        send_resp = 1'b0;
  logic        resp_busy, resp_done, trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_framer #(.CMD_BYTES(CB), .RESP_BYTES(RB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun),
    .frame_err(frame_err), .resp(resp), .send_resp(send_resp), .resp_busy(resp_busy),
    .resp_done(resp_done), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  typedef struct {logic [23:0] cmd; bit ovr;} cmd_exp_t;

  int checks = 0, failures = 0;
  cmd_exp_t   exp_cmd[$];
  logic [7:0] exp_tx[$];
  logic [7:0] part[$];
  int idle_cnt = 0, exp_ferr = 0, ferr_seen = 0, exp_done = 0, done_seen = 0;
  bit m_rdy = 0, prev_rdy = 0, prev_busy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // one RX clock: drive, update the frame model, advance an edge
  task automatic rx_step(input bit v, input logic [7:0] b, input bit c);
    cmd_exp_t e;
    rx_rdy = v; rx_data = v ? b : 8'($urandom); clr_cmd_rdy = c;
    if (v) begin
      part.push_back(b);
      idle_cnt = 0;
      if (part.size() == CB) begin
        e.cmd = '0;
        for (int i = 0; i < CB; i++) e.cmd = (e.cmd << 8) | 24'(part[i]);
        e.ovr = m_rdy;
        exp_cmd.push_back(e);
        m_rdy = 1;
        part.delete();
      end else if (c) m_rdy = 0;
    end else begin
      if (c) m_rdy = 0;
      if (part.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == TO) begin
          part.delete();
          idle_cnt = 0;
          exp_ferr++;
        end
      end
    end
    #1 chk("clr_rx_rdy", clr_rx_rdy, v);
    @(posedge clk); #1;
    chk("cmd_rdy", cmd_rdy, m_rdy);
    rx_rdy = 0; clr_cmd_rdy = 0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (resp_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tx_idle_timeout", resp_busy, 0);
  endtask

  task automatic send_r(input logic [15:0] v, input bit poke);
    wait_tx_idle();
    resp = v; send_resp = 1;
    @(posedge clk); #1;
    send_resp = 0;
    exp_tx.push_back(v[15:8]);
    exp_tx.push_back(v[7:0]);
    exp_done++;
    chk("busy_after_send", resp_busy, 1);
    chk("trmt_latency", trmt, 1);
    chk("tx_first_byte", tx_data, v[15:8]);
    resp = ~v;
    if (poke) begin
      repeat (2) @(posedge clk);
      #1 resp = 16'($urandom); send_resp = 1;
      @(posedge clk); #1 send_resp = 0;
    end
    wait_tx_idle();
  endtask

  task automatic chk_all_zero();
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_resp_busy", resp_busy, 0);
    chk("rst_resp_done", resp_done, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
  endtask

  // UART transmitter: tx_done drops on trmt and rises a few clocks later
  initial begin
    forever begin
      @(negedge clk);
      if (trmt) begin
        @(posedge clk); #1 tx_done = 0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 tx_done = 1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    cmd_exp_t e;
    logic [7:0] b;
    if ((cmd_rdy && !prev_rdy) || overrun) begin
      if (exp_cmd.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_cmd actual=%0h required=none", cmd);
      end else begin
        e = exp_cmd.pop_front();
        chk("cmd", cmd, e.cmd);
        chk("overrun", overrun, e.ovr);
      end
    end
    if (frame_err) ferr_seen++;
    if (trmt) begin
      if (exp_tx.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_trmt actual=%0h required=none", tx_data);
      end else begin
        b = exp_tx.pop_front();
        chk("tx_data", tx_data, b);
      end
    end
    if (!resp_busy) chk("tx_data_idle", tx_data, 0);
    if (resp_done) begin
      done_seen++;
      chk("busy_at_done", resp_busy, 0);
      chk("busy_before_done", prev_busy, 1);
    end
    prev_rdy  = cmd_rdy;
    prev_busy = resp_busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_all_zero();
    rst = 0;
    fork
      begin
        rx_step(1, 8'hA5, 0); rx_step(1, 8'h5A, 0); rx_step(1, 8'h3C, 0);
        chk("cmd_directed", cmd, 24'hA55A3C);
        rx_step(0, 8'h00, 1);
        rx_step(1, 8'h11, 0);
        repeat (TO) rx_step(0, 8'h00, 0);
        chk("frame_err_pulse", frame_err, 1);
        rx_step(1, 8'h22, 0); rx_step(1, 8'h33, 0); rx_step(1, 8'h44, 0);
        chk("cmd_after_timeout", cmd, 24'h223344);
        rx_step(0, 8'h00, 1);
        rx_step(1, 8'h01, 0); rx_step(1, 8'h02, 0); rx_step(1, 8'h03, 0);
        rx_step(1, 8'h04, 0); rx_step(1, 8'h05, 0); rx_step(1, 8'h06, 1);
        chk("cmd_overrun_value", cmd, 24'h040506);
        rx_step(0, 8'h00, 1);
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 19) == 0)
            repeat ($urandom_range(5, 14)) rx_step(0, 8'h00, 0);
          else
            rx_step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 5) == 0);
        end
        repeat (TO + 2) rx_step(0, 8'h00, 1);
      end
      begin
        send_r(16'hBEEF, 1);
        for (int i = 0; i < 8; i++) send_r(16'($urandom), 1'($urandom_range(0, 1)));
      end
    join

    // reset with a partial frame held and a byte in flight
    repeat (6) @(posedge clk);
    #1 resp = 16'hCAFE; send_resp = 1;
    rx_step(1, 8'h77, 0);
    send_resp = 0;
    exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE); exp_done++;
    rx_step(0, 8'h00, 0);
    rst = 1;
    @(posedge clk); #1;
    part.delete(); idle_cnt = 0; m_rdy = 0;
    exp_tx.delete(); exp_done--;
    chk_all_zero();
    rst = 0;
    repeat (6) @(posedge clk);
    #1;
    rx_step(1, 8'h12, 0); rx_step(1, 8'h34, 0); rx_step(1, 8'h56, 0);
    chk("cmd_after_reset", cmd, 24'h123456);
    rx_step(0, 8'h00, 1);
    send_r(16'h1234, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("frame_err_count", ferr_seen, exp_ferr);
    chk("resp_done_count", done_seen, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
